// File: rtl/alu_pkg.sv
// Shared op codes, widths and condition-code reset value for the pipelined Y86 ALU.
package alu_pkg;
  localparam int ALU_OP_W = 3;

  localparam logic [ALU_OP_W-1:0] ALU_ADD = 3'b000;
  localparam logic [ALU_OP_W-1:0] ALU_SUB = 3'b001;
  localparam logic [ALU_OP_W-1:0] ALU_AND = 3'b010;
  localparam logic [ALU_OP_W-1:0] ALU_XOR = 3'b011;
  localparam logic [ALU_OP_W-1:0] ALU_OR  = 3'b100;
  localparam logic [ALU_OP_W-1:0] ALU_SHL = 3'b101;
  localparam logic [ALU_OP_W-1:0] ALU_SAR = 3'b110;

  typedef struct packed {
    logic zf;
    logic sf;
    logic of;
  } cc_t;

  localparam cc_t CC_RST = '{zf: 1'b1, sf: 1'b0, of: 1'b0};
endpackage

// File: rtl/alu_pipe_cc_if.sv
// Handshake/data bundle between decode, the ALU pipe and the memory stage.
interface alu_pipe_cc_if import alu_pkg::*; #(parameter int WIDTH = 64);
  logic                in_valid;
  logic                in_ready;
  logic [ALU_OP_W-1:0] in_op;
  logic [WIDTH-1:0]    in_a;
  logic [WIDTH-1:0]    in_b;
  logic                in_set_cc;
  logic                out_valid;
  logic                out_ready;
  logic [WIDTH-1:0]    out_result;
  logic                out_of;
  logic                out_illegal;
  logic                cc_zf;
  logic                cc_sf;
  logic                cc_of;

  modport master (
    output in_valid, in_op, in_a, in_b, in_set_cc, out_ready,
    input  in_ready, out_valid, out_result, out_of, out_illegal, cc_zf, cc_sf, cc_of
  );

  modport slave (
    input  in_valid, in_op, in_a, in_b, in_set_cc, out_ready,
    output in_ready, out_valid, out_result, out_of, out_illegal, cc_zf, cc_sf, cc_of
  );
endinterface

// File: rtl/alu_core.sv
// Combinational ALU: result, signed overflow and illegal-op flag.
// ALU_EXT_OPS_EN enables OR/SHL/SAR; otherwise every 1xx op code is illegal.
module alu_core import alu_pkg::*; #(parameter int WIDTH = 64) (
  input  logic [ALU_OP_W-1:0] i_op,
  input  logic [WIDTH-1:0]    i_a,
  input  logic [WIDTH-1:0]    i_b,
  output logic [WIDTH-1:0]    o_result,
  output logic                o_of,
  output logic                o_illegal
);
`ifdef ALU_EXT_OPS_EN
  localparam int SH_W = $clog2(WIDTH);
  logic [SH_W-1:0] w_sh;
  assign w_sh = i_b[SH_W-1:0];
`endif

  logic [WIDTH-1:0] w_sum, w_diff;
  assign w_sum  = i_a + i_b;
  assign w_diff = i_a - i_b;

  always_comb begin
    o_result  = '0;
    o_of      = 1'b0;
    o_illegal = 1'b0;
    case (i_op)
      ALU_ADD: begin
        o_result = w_sum;
        o_of     = (i_a[WIDTH-1] == i_b[WIDTH-1]) && (w_sum[WIDTH-1] != i_a[WIDTH-1]);
      end
      ALU_SUB: begin
        o_result = w_diff;
        o_of     = (i_a[WIDTH-1] != i_b[WIDTH-1]) && (w_diff[WIDTH-1] != i_a[WIDTH-1]);
      end
      ALU_AND: o_result = i_a & i_b;
      ALU_XOR: o_result = i_a ^ i_b;
`ifdef ALU_EXT_OPS_EN
      ALU_OR:  o_result = i_a | i_b;
      ALU_SHL: o_result = i_a << w_sh;
      ALU_SAR: o_result = WIDTH'($signed(i_a) >>> w_sh);
`endif
      default: o_illegal = 1'b1;
    endcase
  end
endmodule

// File: rtl/alu_pipe_cc.sv
// Pipelined ALU with valid/ready handshake and a ZF/SF/OF condition-code register.
// ALU_EXT_OPS_EN (see alu_core) selects the extended op set.
module alu_pipe_cc import alu_pkg::*; #(
  parameter int WIDTH  = 64,
  parameter int STAGES = 2
) (
  input logic         clk,
  input logic         rst,
  alu_pipe_cc_if.slave bus
);
  logic [WIDTH-1:0] w_core_res;
  logic             w_core_of, w_core_ill, w_acc;

  logic [STAGES:1]              r_vld, r_of, r_ill, r_scc, w_go;
  logic [STAGES+1:1]            w_free;
  logic [STAGES:1][WIDTH-1:0]   r_res;
  cc_t                          r_cc;

  alu_core #(.WIDTH(WIDTH)) u_core (
    .i_op      (bus.in_op),
    .i_a       (bus.in_a),
    .i_b       (bus.in_b),
    .o_result  (w_core_res),
    .o_of      (w_core_of),
    .o_illegal (w_core_ill)
  );

  // Ready ripples back from the consumer: a stage is free if empty or moving on this cycle.
  always_comb begin
    w_go               = '0;
    w_free             = '0;
    w_free[STAGES+1]   = bus.out_ready;
    for (int k = STAGES; k >= 1; k--) begin
      w_go[k]   = r_vld[k] && w_free[k+1];
      w_free[k] = !r_vld[k] || w_go[k];
    end
  end

  assign w_acc = bus.in_valid && w_free[1];

  always_ff @(posedge clk) begin
    if (rst) begin
      r_vld <= '0;
      r_res <= '0;
      r_of  <= '0;
      r_ill <= '0;
      r_scc <= '0;
      r_cc  <= CC_RST;
    end else begin
      if (w_free[1]) begin
        r_vld[1] <= w_acc;
        if (w_acc) begin
          r_res[1] <= w_core_res;
          r_of[1]  <= w_core_of;
          r_ill[1] <= w_core_ill;
          r_scc[1] <= bus.in_set_cc && !w_core_ill;
        end
      end
      for (int k = 2; k <= STAGES; k++) begin
        if (w_free[k]) begin
          r_vld[k] <= w_go[k-1];
          if (w_go[k-1]) begin
            r_res[k] <= r_res[k-1];
            r_of[k]  <= r_of[k-1];
            r_ill[k] <= r_ill[k-1];
            r_scc[k] <= r_scc[k-1];
          end
        end
      end
      // Illegal ops already had their set_cc cleared at stage 1.
      if (w_go[STAGES] && r_scc[STAGES]) begin
        r_cc.zf <= (r_res[STAGES] == '0);
        r_cc.sf <= r_res[STAGES][WIDTH-1];
        r_cc.of <= r_of[STAGES];
      end
    end
  end

  assign bus.in_ready    = w_free[1];
  assign bus.out_valid   = r_vld[STAGES];
  assign bus.out_result  = r_res[STAGES];
  assign bus.out_of      = r_of[STAGES];
  assign bus.out_illegal = r_ill[STAGES];
  assign bus.cc_zf       = r_cc.zf;
  assign bus.cc_sf       = r_cc.sf;
  assign bus.cc_of       = r_cc.of;
endmodule

// File: tb/tb_alu_pipe_cc.sv
// Directed + randomized bench for alu_pipe_cc against a queue-based reference model.
module tb_alu_pipe_cc;
  localparam int WIDTH  = 64;
  localparam int STAGES = 2;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  alu_pipe_cc_if #(.WIDTH(WIDTH)) bus();
  alu_pipe_cc #(.WIDTH(WIDTH), .STAGES(STAGES)) dut (.clk(clk), .rst(rst), .bus(bus));

  typedef struct {
    logic [63:0] res;
    logic        of;
    logic        ill;
    logic        scc;
    int          acc;
  } ent_t;

  ent_t q[$];
  logic mzf, msf, mof;
  int   cyc = 0;
  int   tests = 0;
  int   fails = 0;

  task automatic chk1(input string tag, input logic obs, input logic exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0b expected=%0b", tag, obs, exp);
    end
  endtask

  task automatic chk64(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Reference: overflow found by doing the arithmetic one bit wider.
  task automatic ref_alu(input logic [2:0] op, input logic [63:0] a, input logic [63:0] b,
                         output logic [63:0] r, output logic of, output logic ill);
    logic [64:0] w;
    r = '0; of = 1'b0; ill = 1'b0;
    case (op)
      3'd0: begin w = {a[63], a} + {b[63], b}; r = w[63:0]; of = w[64] ^ w[63]; end
      3'd1: begin w = {a[63], a} - {b[63], b}; r = w[63:0]; of = w[64] ^ w[63]; end
      3'd2: r = a & b;
      3'd3: r = a ^ b;
`ifdef ALU_EXT_OPS_EN
      3'd4: r = a | b;
      3'd5: r = a << b[5:0];
      3'd6: r = $signed(a) >>> b[5:0];
`endif
      default: ill = 1'b1;
    endcase
  endtask

  task automatic drive(input logic v, input logic [2:0] op, input logic [63:0] a,
                       input logic [63:0] b, input logic scc, input logic ordy);
    bus.in_valid  = v;
    bus.in_op     = op;
    bus.in_a      = a;
    bus.in_b      = b;
    bus.in_set_cc = scc;
    bus.out_ready = ordy;
  endtask

  // One clock: check outputs mid-cycle against the model, then advance the model at the edge.
  task automatic tick(output logic acc);
    logic exp_rdy, exp_ov, ret;
    ent_t e;
    @(negedge clk);
    exp_rdy = (q.size() < STAGES) || bus.out_ready;
    exp_ov  = (q.size() > 0) && (cyc >= q[0].acc + STAGES);
    chk1("in_ready", bus.in_ready, exp_rdy);
    chk1("out_valid", bus.out_valid, exp_ov);
    if (exp_ov) begin
      chk64("out_result", bus.out_result, q[0].res);
      chk1("out_of", bus.out_of, q[0].of);
      chk1("out_illegal", bus.out_illegal, q[0].ill);
    end
    chk1("cc_zf", bus.cc_zf, mzf);
    chk1("cc_sf", bus.cc_sf, msf);
    chk1("cc_of", bus.cc_of, mof);
    acc = bus.in_valid && exp_rdy;
    ret = exp_ov && bus.out_ready;
    if (acc) begin
      ref_alu(bus.in_op, bus.in_a, bus.in_b, e.res, e.of, e.ill);
      e.scc = bus.in_set_cc;
      e.acc = cyc;
    end
    @(posedge clk);
    if (ret) begin
      ent_t f;
      f = q.pop_front();
      if (f.scc && !f.ill) begin
        mzf = (f.res == 64'd0);
        msf = f.res[63];
        mof = f.of;
      end
    end
    if (acc) q.push_back(e);
    cyc++;
    #1;
  endtask

  task automatic send(input logic [2:0] op, input logic [63:0] a, input logic [63:0] b,
                      input logic scc, input logic ordy);
    logic acc;
    acc = 1'b0;
    for (int i = 0; i < 20 && !acc; i++) begin
      drive(1'b1, op, a, b, scc, ordy);
      tick(acc);
    end
    tests++;
    assert (acc) else begin
      fails++;
      $error("FAIL send_timeout observed=0 expected=1");
    end
    bus.in_valid = 1'b0;
  endtask

  task automatic idle(input int n, input logic ordy);
    logic acc;
    for (int i = 0; i < n; i++) begin
      drive(1'b0, 3'd0, 64'd0, 64'd0, 1'b0, ordy);
      tick(acc);
    end
  endtask

  task automatic do_reset();
    bus.in_valid = 1'b0;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    q.delete();
    mzf = 1'b1; msf = 1'b0; mof = 1'b0;
    cyc++;
    chk1("rst_out_valid", bus.out_valid, 1'b0);
    chk64("rst_out_result", bus.out_result, 64'd0);
    chk1("rst_out_of", bus.out_of, 1'b0);
    chk1("rst_out_illegal", bus.out_illegal, 1'b0);
    chk1("rst_cc_zf", bus.cc_zf, 1'b1);
    chk1("rst_cc_sf", bus.cc_sf, 1'b0);
    chk1("rst_cc_of", bus.cc_of, 1'b0);
    chk1("rst_in_ready", bus.in_ready, 1'b1);
  endtask

  function automatic logic [63:0] pick();
    case ($urandom_range(0, 5))
      0:       return 64'h7FFF_FFFF_FFFF_FFFF;
      1:       return 64'h8000_0000_0000_0000;
      2:       return 64'hFFFF_FFFF_FFFF_FFFF;
      3:       return 64'd0;
      default: return {$urandom(), $urandom()};
    endcase
  endfunction

  initial begin
    logic acc;
    rst = 1'b1;
    drive(1'b0, 3'd0, 64'd0, 64'd0, 1'b0, 1'b1);
    do_reset();

    // ADD 19+10 with CC update
    send(3'd0, 64'd19, 64'd10, 1'b1, 1'b1);
    idle(STAGES + 1, 1'b1);
    chk1("add_cc_zf", bus.cc_zf, 1'b0);
    chk1("add_cc_sf", bus.cc_sf, 1'b0);
    chk1("add_cc_of", bus.cc_of, 1'b0);

    // Signed overflow on ADD
    send(3'd0, 64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 1'b1, 1'b1);
    idle(STAGES + 1, 1'b1);
    chk1("ovf_cc_zf", bus.cc_zf, 1'b0);
    chk1("ovf_cc_sf", bus.cc_sf, 1'b1);
    chk1("ovf_cc_of", bus.cc_of, 1'b1);

    // SUB to zero sets ZF; XOR without set_cc leaves it
    send(3'd1, 64'h1234, 64'h1234, 1'b1, 1'b1);
    send(3'd3, 64'hF0, 64'h0F, 1'b0, 1'b1);
    idle(STAGES + 1, 1'b1);
    chk1("xor_cc_zf", bus.cc_zf, 1'b1);

    // Back-pressure: third op must stall until the consumer drains
    send(3'd0, 64'd1, 64'd2, 1'b1, 1'b0);
    send(3'd1, 64'd5, 64'd7, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 3'd2, 64'hFF00, 64'h0FF0, 1'b1, 1'b0);
      tick(acc);
    end
    chk1("bp_in_ready", bus.in_ready, 1'b0);
    send(3'd2, 64'hFF00, 64'h0FF0, 1'b1, 1'b1);
    idle(STAGES + 2, 1'b1);

    // Reset with two ops in flight
    send(3'd0, 64'd3, 64'd4, 1'b1, 1'b0);
    send(3'd1, 64'd0, 64'd9, 1'b1, 1'b0);
    do_reset();
    idle(STAGES + 2, 1'b1);

    // Op 101: SHL when extended ops are built in, illegal otherwise
    send(3'd5, 64'd1, 64'd4, 1'b1, 1'b1);
    idle(STAGES + 1, 1'b1);

    // Randomized traffic with random back-pressure
    for (int i = 0; i < 400; i++) begin
      drive($urandom_range(0, 3) != 0, 3'($urandom_range(0, 7)), pick(), pick(),
            1'($urandom_range(0, 1)), $urandom_range(0, 3) != 0);
      tick(acc);
    end
    idle(STAGES + 2, 1'b1);
    chk1("final_empty", bus.out_valid, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
